// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the cascaded BCD up/down counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_MIN  = 4'd0;
  localparam logic       DIR_UP   = 1'b1;
  localparam logic       DIR_DOWN = 1'b0;

  // Out-of-range load digits saturate at 9 so a decade never holds 10..15.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade: steps when step_in is high, passes carry/borrow on via step_out.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk_div,
  input  logic       BTN0,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step_in,
  input  logic       dir_bit,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       step_out
);

  logic       at_term;
  logic [3:0] next_digit;

  // A decade rolls over in the chosen direction at 9 (up) or 0 (down).
  assign at_term  = (dir_bit == DIR_UP) ? (digit == BCD_MAX) : (digit == BCD_MIN);
  assign step_out = step_in & at_term;

  always_comb begin
    next_digit = digit;
    if (dir_bit == DIR_UP)
      next_digit = at_term ? BCD_MIN : digit + 4'd1;
    else
      next_digit = at_term ? BCD_MAX : digit - 4'd1;
  end

  always_ff @(posedge clk_div or negedge BTN0) begin
    if (!BTN0)
      digit <= BCD_MIN;
    else if (load)
      digit <= bcd_clamp(load_digit);
    else if (step_in && !hold)
      digit <= next_digit;
  end

endmodule

// File: rtl/bcd_updown_counter_n.sv
// DIGITS-decade BCD up/down counter with load, wrap/saturate mode and terminal-count pulse.
module bcd_updown_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk_div,
  input  logic                BTN0,
  input  logic                en,
  input  logic                dir_bit,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] BCD,
  output logic                tc,
  output logic                at_max,
  output logic                at_zero
);

  logic [DIGITS:0] step;
  logic            terminal;
  logic            hold;

  // The step request ripples up the chain; it escapes the top decade only
  // when the whole counter sits at its terminal value.
  assign step[0]  = en;
  assign terminal = step[DIGITS];
  assign hold     = !WRAP && terminal;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk_div    (clk_div),
      .BTN0       (BTN0),
      .load       (load),
      .load_digit (load_val[4*k +: 4]),
      .step_in    (step[k]),
      .dir_bit    (dir_bit),
      .hold       (hold),
      .digit      (BCD[4*k +: 4]),
      .step_out   (step[k+1])
    );
  end

  always_ff @(posedge clk_div or negedge BTN0) begin
    if (!BTN0)
      tc <= 1'b0;
    else
      tc <= !load && terminal;
  end

  always_comb begin
    at_max  = 1'b1;
    at_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (BCD[4*k +: 4] != BCD_MAX) at_max  = 1'b0;
      if (BCD[4*k +: 4] != BCD_MIN) at_zero = 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: a wrapping and a saturating 4-decade instance
// share stimulus and are compared against a decimal reference model.
module tb_bcd_updown_counter_n;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int MAXV   = 9999;

  logic         clk_div = 1'b0;
  logic         BTN0;
  logic         en;
  logic         dir_bit;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] bcd_w, bcd_s;
  logic         tc_w, tc_s, max_w, max_s, zero_w, zero_s;

  int total = 0;
  int bad   = 0;

  // Index 0 models the wrapping instance, index 1 the saturating one.
  int model_val[2];
  bit model_tc[2];

  always #5 clk_div = ~clk_div;

  bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b1)) u_wrap (
    .clk_div (clk_div), .BTN0 (BTN0), .en (en), .dir_bit (dir_bit),
    .load (load), .load_val (load_val), .BCD (bcd_w), .tc (tc_w),
    .at_max (max_w), .at_zero (zero_w)
  );

  bcd_updown_counter_n #(.DIGITS(DIGITS), .WRAP(1'b0)) u_sat (
    .clk_div (clk_div), .BTN0 (BTN0), .en (en), .dir_bit (dir_bit),
    .load (load), .load_val (load_val), .BCD (bcd_s), .tc (tc_s),
    .at_max (max_s), .at_zero (zero_s)
  );

  function automatic logic [W-1:0] toBcd(input int v);
    logic [W-1:0] r;
    int           rem;
    r   = '0;
    rem = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rem % 10);
      rem         = rem / 10;
    end
    return r;
  endfunction

  function automatic int loadValue(input logic [W-1:0] lv);
    int         v;
    int         scale;
    logic [3:0] d;
    v     = 0;
    scale = 1;
    for (int i = 0; i < DIGITS; i++) begin
      d     = lv[4*i +: 4];
      v     = v + ((d > 4'd9) ? 9 : int'(d)) * scale;
      scale = scale * 10;
    end
    return v;
  endfunction

  function automatic logic anyBadDigit(input logic [W-1:0] b);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (b[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      model_val[m] = 0;
      model_tc[m]  = 1'b0;
    end
  endtask

  // Decimal behaviour: whole-number +/-1, with wrap or saturate at 0 and 9999.
  task automatic modelStep(input logic e, input logic d, input logic l, input logic [W-1:0] lv);
    for (int m = 0; m < 2; m++) begin
      if (l) begin
        model_val[m] = loadValue(lv);
        model_tc[m]  = 1'b0;
      end else if (e && d) begin
        if (model_val[m] == MAXV) begin
          model_tc[m] = 1'b1;
          if (m == 0) model_val[m] = 0;
        end else begin
          model_val[m] = model_val[m] + 1;
          model_tc[m]  = 1'b0;
        end
      end else if (e) begin
        if (model_val[m] == 0) begin
          model_tc[m] = 1'b1;
          if (m == 0) model_val[m] = MAXV;
        end else begin
          model_val[m] = model_val[m] - 1;
          model_tc[m]  = 1'b0;
        end
      end else begin
        model_tc[m] = 1'b0;
      end
    end
  endtask

  task automatic checkState();
    checkOutput("bcd_wrap", bcd_w, toBcd(model_val[0]));
    checkOutput("bcd_sat",  bcd_s, toBcd(model_val[1]));
    checkOutput("tc_wrap",  W'(tc_w), W'(model_tc[0]));
    checkOutput("tc_sat",   W'(tc_s), W'(model_tc[1]));
    checkOutput("max_wrap", W'(max_w),  W'(model_val[0] == MAXV));
    checkOutput("zero_wrap", W'(zero_w), W'(model_val[0] == 0));
    checkOutput("max_sat",  W'(max_s),  W'(model_val[1] == MAXV));
    checkOutput("zero_sat", W'(zero_s), W'(model_val[1] == 0));
    checkOutput("digit_range", W'(anyBadDigit(bcd_w) | anyBadDigit(bcd_s)), '0);
  endtask

  // Inputs change 1 time unit after an edge, so they are stable well before the next one.
  task automatic applyStimulus(input logic e, input logic d, input logic l, input logic [W-1:0] lv);
    en       = e;
    dir_bit  = d;
    load     = l;
    load_val = lv;
    @(posedge clk_div);
    modelStep(e, d, l, lv);
    #1;
    checkState();
  endtask

  initial begin
    logic [W-1:0] lv;
    int           pick;

    BTN0     = 1'b0;
    en       = 1'b0;
    dir_bit  = 1'b1;
    load     = 1'b0;
    load_val = '0;
    modelReset();
    #3;
    checkState();
    #9 BTN0 = 1'b1;

    $display("[TB] asynchronous reset");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0037);
    checkOutput("load_0037", bcd_w, 16'h0037);
    #2 BTN0 = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_bcd", bcd_w, 16'h0000);
    checkOutput("async_rst_tc", W'(tc_w), '0);
    checkState();
    #2 BTN0 = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("first_after_rst", bcd_w, 16'h0001);

    $display("[TB] up carry and wrap");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h9998);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("up_9999", bcd_w, 16'h9999);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("up_wrap_bcd", bcd_w, 16'h0000);
    checkOutput("up_wrap_tc", W'(tc_w), W'(1'b1));
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("up_after_wrap", bcd_w, 16'h0001);
    checkOutput("up_tc_one_cycle", W'(tc_w), '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0009);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("up_carry_10", bcd_w, 16'h0010);

    $display("[TB] down borrow and wrap");
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0001);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("down_zero", W'(zero_w), W'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("down_wrap_bcd", bcd_w, 16'h9999);
    checkOutput("down_wrap_tc", W'(tc_w), W'(1'b1));
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("down_9998", bcd_w, 16'h9998);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0010);
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("down_borrow_09", bcd_w, 16'h0009);

    $display("[TB] saturate");
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h9999);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0);
      checkOutput("sat_hold_bcd", bcd_s, 16'h9999);
      checkOutput("sat_hold_tc", W'(tc_s), W'(1'b1));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("sat_turn_bcd", bcd_s, 16'h9998);
    checkOutput("sat_turn_tc", W'(tc_s), '0);

    $display("[TB] load priority and clamp");
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h12A5);
    checkOutput("clamp_bcd", bcd_w, 16'h1295);
    checkOutput("clamp_tc", W'(tc_w), '0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, $urandom_range(0, 1) == 1, 1'b0, '0);
      checkOutput("idle_hold", bcd_w, 16'h1295);
    end

    $display("[TB] random soak");
    for (int i = 0; i < 10000; i++) begin
      pick = $urandom_range(0, 7);
      case (pick)
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        2:       lv = 16'h9998;
        3:       lv = 16'h0001;
        default: lv = W'($urandom);
      endcase
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 15) == 0, lv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
